// File: rtl/drive_arbiter.sv
// Fixed-priority arbiter for car motion/barrier commands from three sources.
// Enforces a minimum hold before preemption and a dead-time between grants.
`timescale 1ns/1ps
module drive_arbiter #(
    parameter int unsigned DEAD_TIME = 50,
    parameter int unsigned MIN_HOLD  = 25,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] req,
    input  logic [5:0] cmd_man,
    input  logic [5:0] cmd_semi,
    input  logic [5:0] cmd_auto,
    output logic [2:0] grant,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       place_barrier_signal,
    output logic       destroy_barrier_signal,
    output logic [1:0] out_state,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_DEAD  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;

    logic [2:0] winner;
    logic       own_req;
    logic       higher_req;
    logic       hold_full;
    logic       dead_done;
    logic [5:0] sel_cmd;
    logic [5:0] gated_cmd;

    // Lowest-index request wins
    always_comb begin
        winner = 3'b000;
        if (req[0])      winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
    end

    // grant_q - 1 masks exactly the bits of higher priority than the one-hot grant
    assign own_req    = |(req & grant_q);
    assign higher_req = |(req & 3'(grant_q - 3'd1));
    assign hold_full  = (hold_cnt_q == CNT_W'(MIN_HOLD));
    assign dead_done  = (dead_cnt_q == CNT_W'(DEAD_TIME - 1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (|req)) begin
                    state_d    = ST_GRANT;
                    grant_d    = winner;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!enable || !own_req || (higher_req && hold_full)) begin
                    state_d    = ST_DEAD;
                    grant_d    = 3'b000;
                    hold_cnt_d = '0;
                    dead_cnt_d = '0;
                end else if (!hold_full) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_DEAD: begin
                if (dead_done) begin
                    dead_cnt_d = '0;
                    if (enable && (|req)) begin
                        state_d    = ST_GRANT;
                        grant_d    = winner;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = 3'b000;
                hold_cnt_d = '0;
                dead_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 3'b000;
            hold_cnt_q <= '0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    // Command path is combinational from the registered grant, so reset clears it at once
    always_comb begin
        case (grant_q)
            3'b001:  sel_cmd = cmd_man;
            3'b010:  sel_cmd = cmd_semi;
            3'b100:  sel_cmd = cmd_auto;
            default: sel_cmd = 6'b000000;
        endcase
    end

    // Opposing pairs cancel: {fwd,back}, {left,right}, {place,destroy}
    always_comb begin
        gated_cmd = sel_cmd;
        if (sel_cmd[5] && sel_cmd[4]) gated_cmd[5:4] = 2'b00;
        if (sel_cmd[3] && sel_cmd[2]) gated_cmd[3:2] = 2'b00;
        if (sel_cmd[1] && sel_cmd[0]) gated_cmd[1:0] = 2'b00;
    end

    assign grant                  = grant_q;
    assign move_forward           = gated_cmd[5];
    assign move_backward          = gated_cmd[4];
    assign turn_left              = gated_cmd[3];
    assign turn_right             = gated_cmd[2];
    assign place_barrier_signal   = gated_cmd[1];
    assign destroy_barrier_signal = gated_cmd[0];
    assign out_state              = state_q;
    assign busy                   = (state_q != ST_IDLE);

endmodule
